// File: rtl/pulse_sched_pkg.sv
// pulse_sched_pkg: shared types and constants for the pulse scheduler.
//   state_e      scheduler FSM encoding (IDLE / ISSUE / WAIT)
//   TMO_DEFAULT  default completion timeout in clk cycles
//   wrap_idx     (a + b) mod n for a, b < n, used by the round-robin search
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int TMO_DEFAULT = 255;

    function automatic int wrap_idx(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/pulse_sched_rr_pick.sv
// rr_pick: round-robin selector over a request vector.
// Searches req starting at position rr and wrapping; the first set bit wins.
// Ports:
//   req    in   N     request bits
//   rr     in   RRW   search start position (always < N)
//   grant  out  RRW   index of the winning request (0 when none)
//   any    out  1     at least one request bit is set
module rr_pick
    import pulse_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int RRW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [RRW-1:0] rr,
    output logic [RRW-1:0] grant,
    output logic           any
);

    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[RRW'(wrap_idx(int'(rr), i, N))]) begin
                any   = 1'b1;
                grant = RRW'(wrap_idx(int'(rr), i, N));
            end
        end
    end

endmodule

// File: rtl/pulse_sched.sv
// pulse_sched: schedules per-requester event pulses onto one shared
// clock-crossing pulse channel, one transfer outstanding at a time.
//
// Optional feature macro: PULSE_SCHED_TIMEOUT_EN
//   defined   -> WAIT is abandoned after TMO cycles without chan_done
//   undefined -> no counter, timeout_o tied low, WAIT holds until chan_done
//
// Ports:
//   clk         in   1    single clock, rising edge
//   reset_l     in   1    asynchronous active-low reset
//   req_i       in   N    one-cycle event pulses, one per requester
//   chan_pulse  out  1    one-cycle launch pulse into the channel
//   chan_id     out  IDW  requester carried by the current transfer
//   chan_done   in   1    channel acknowledge of the outstanding transfer
//   pending_o   out  N    registered pending-request bits
//   busy_o      out  1    high while in ISSUE or WAIT
//   merge_o     out  N    request hit an already-pending bit (folded in)
//   timeout_o   out  1    transfer abandoned after TMO cycles
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer outstanding; grant next pending bit from rr
// ISSUE | chan_pulse high for this cycle, pending[grant] cleared
// WAIT  | transfer outstanding, waiting for chan_done (or timeout)
module pulse_sched
    import pulse_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int TMO = TMO_DEFAULT
) (
    input  logic           clk,
    input  logic           reset_l,
    input  logic [N-1:0]   req_i,
    output logic           chan_pulse,
    output logic [IDW-1:0] chan_id,
    input  logic           chan_done,
    output logic [N-1:0]   pending_o,
    output logic           busy_o,
    output logic [N-1:0]   merge_o,
    output logic           timeout_o
);

    localparam int RRW = $clog2(N);

    state_e         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   merge_q, merge_d;
    logic [N-1:0]   clr;
    logic [RRW-1:0] rr_q, rr_d;
    logic [RRW-1:0] grant_q, grant_d;
    logic [RRW-1:0] rr_next;
    logic [RRW-1:0] pick_grant;
    logic           pick_any;
    logic           pulse_q, pulse_d;
    logic           tmo_hit;

    rr_pick #(
        .N   (N),
        .RRW (RRW)
    ) u_rr_pick (
        .req   (pending_q),
        .rr    (rr_q),
        .grant (pick_grant),
        .any   (pick_any)
    );

    assign rr_next = (grant_q == RRW'(N - 1)) ? '0 : grant_q + RRW'(1);

`ifdef PULSE_SCHED_TIMEOUT_EN
    // Down-counter loaded while in ISSUE so the terminal count lands on the
    // TMO-th cycle spent in WAIT.
    localparam logic [15:0] TMO_LOAD = 16'(TMO - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q, timeout_d;

    assign tmo_hit = (tmo_cnt_q == 16'd0);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ISSUE) begin
            tmo_cnt_d = TMO_LOAD;
        end else if (state_q == WAIT && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q - 16'd1;
        end
        // chan_done on the terminal cycle still counts as a normal completion
        timeout_d = (state_q == WAIT) && !chan_done && tmo_hit;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;

    // TMO only sizes the optional watchdog; this empty range guard keeps the
    // parameter referenced in the watchdog-less build.
    if (TMO < 1 || TMO > 65535) begin : g_tmo_out_of_range
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        pulse_d = 1'b0;
        clr     = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    pulse_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                clr[grant_q] = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                if (chan_done || tmo_hit) begin
                    rr_d    = rr_next;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A request landing on the bit being cleared is a fresh request, so
        // it survives the clear and is not reported as a merge.
        pending_d = (pending_q & ~clr) | req_i;
        merge_d   = req_i & pending_q & ~clr;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= IDLE;
            pending_q <= '0;
            merge_q   <= '0;
            rr_q      <= '0;
            grant_q   <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            merge_q   <= merge_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            pulse_q   <= pulse_d;
        end
    end

    // pulse_q is set on the IDLE->ISSUE edge, so it is high for exactly the
    // ISSUE cycle and comes straight from a flop into the channel.
    assign chan_pulse = pulse_q;
    assign chan_id    = IDW'(grant_q);
    assign pending_o  = pending_q;
    assign busy_o     = (state_q != IDLE);
    assign merge_o    = merge_q;

endmodule

// File: tb/tb_pulse_sched.sv
// tb_pulse_sched: scoreboard bench for pulse_sched (N=4, IDW=2, TMO=8).
// Expected channel IDs are queued when requests are driven and popped when
// chan_pulse is seen. Timeout scenario is compiled with PULSE_SCHED_TIMEOUT_EN.
module tb_pulse_sched;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TMO = 8;

    logic           clk       = 1'b0;
    logic           reset_l   = 1'b1;
    logic [N-1:0]   req_i     = '0;
    logic           chan_done = 1'b0;
    logic           chan_pulse;
    logic [IDW-1:0] chan_id;
    logic [N-1:0]   pending_o;
    logic           busy_o;
    logic [N-1:0]   merge_o;
    logic           timeout_o;

    pulse_sched #(
        .N   (N),
        .IDW (IDW),
        .TMO (TMO)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .req_i      (req_i),
        .chan_pulse (chan_pulse),
        .chan_id    (chan_id),
        .chan_done  (chan_done),
        .pending_o  (pending_o),
        .busy_o     (busy_o),
        .merge_o    (merge_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    int             n_cmp = 0;
    int             n_err = 0;
    logic [IDW-1:0] exp_q[$];
    int             done_delay = 5;
    bit             done_en    = 1'b1;
    bit             prev_pulse = 1'b0;
    int             pulse_cnt  = 0;
    int             merge_cnt[N];
    int             tmo_cnt    = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: every launch must match the scoreboard head and last one cycle.
    always @(negedge clk) begin
        if (chan_pulse) begin
            check_eq("pulse_width", 32'(prev_pulse), 32'd0);
            if (exp_q.size() == 0)
                check_eq("unexpected_pulse_id", 32'(chan_id), 32'hFFFF_FFFF);
            else
                check_eq("chan_id", 32'(chan_id), 32'(exp_q.pop_front()));
            pulse_cnt++;
        end
        prev_pulse = chan_pulse;
        for (int k = 0; k < N; k++)
            if (merge_o[k]) merge_cnt[k]++;
        if (timeout_o) tmo_cnt++;
    end

    // Channel model: acknowledge done_delay cycles after each launch.
    initial begin
        forever begin
            @(negedge clk);
            if (chan_pulse && done_en) begin
                repeat (done_delay) @(posedge clk);
                #1 chan_done = 1'b1;
                @(posedge clk);
                #1 chan_done = 1'b0;
            end
        end
    end

    task automatic drive_req(input logic [N-1:0] v);
        @(posedge clk);
        #1 req_i = v;
        @(posedge clk);
        #1 req_i = '0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (!busy_o && pending_o == '0 && !chan_pulse) ok = 1'b1;
        end
        if (!ok) check_eq(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_pulse(input string tag, input int budget);
        bit ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (chan_pulse) ok = 1'b1;
        end
        if (!ok) check_eq(tag, 32'd0, 32'd1);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 reset_l = 1'b0;
        req_i = '0;
        repeat (2) @(posedge clk);
        #1 reset_l = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc0;
        int m0;
        int cyc;
        bit seen;

        for (int k = 0; k < N; k++) merge_cnt[k] = 0;

        // Reset values
        #2 reset_l = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_chan_pulse", 32'(chan_pulse), 32'd0);
        check_eq("rst_chan_id",    32'(chan_id),    32'd0);
        check_eq("rst_pending",    32'(pending_o),  32'd0);
        check_eq("rst_busy",       32'(busy_o),     32'd0);
        check_eq("rst_merge",      32'(merge_o),    32'd0);
        check_eq("rst_timeout",    32'(timeout_o),  32'd0);
        @(posedge clk);
        #1 reset_l = 1'b1;

        // Single request: two-edge latency, id 0, busy drops after done
        done_delay = 5;
        exp_q.push_back(2'd0);
        req_i = 4'b0001;
        @(posedge clk);
        #1 req_i = '0;
        @(negedge clk);
        check_eq("t1_pending_set", 32'(pending_o),  32'h1);
        check_eq("t1_pulse_edge1", 32'(chan_pulse), 32'd0);
        @(negedge clk);
        check_eq("t1_pulse_edge2", 32'(chan_pulse), 32'd1);
        check_eq("t1_busy_issue",  32'(busy_o),     32'd1);
        repeat (3) @(negedge clk);
        check_eq("t1_busy_wait",    32'(busy_o),    32'd1);
        check_eq("t1_pending_clr",  32'(pending_o), 32'd0);
        wait_idle("t1_idle_budget", 50);
        check_eq("t1_busy_done", 32'(busy_o), 32'd0);
        check_eq("t1_sb_empty",  32'(exp_q.size()), 32'd0);

        // All four at once from rr=0: ids 0,1,2,3, rr wraps back to 0
        apply_reset();
        done_delay = 2;
        for (int k = 0; k < N; k++) exp_q.push_back(IDW'(k));
        pc0 = pulse_cnt;
        drive_req(4'b1111);
        wait_idle("t2_idle_budget", 200);
        check_eq("t2_pulses",   32'(pulse_cnt - pc0), 32'd4);
        check_eq("t2_sb_empty", 32'(exp_q.size()),    32'd0);
        check_eq("t2_rr_wrap",  32'(dut.rr_q),        32'd0);

        // Merge: id 2 pending behind a long transfer for id 0, hit twice
        done_delay = 20;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        m0  = merge_cnt[2];
        pc0 = pulse_cnt;
        drive_req(4'b0101);
        repeat (2) @(posedge clk);
        drive_req(4'b0100);
        drive_req(4'b0100);
        wait_idle("t3_idle_budget", 200);
        check_eq("t3_merge2_cnt", 32'(merge_cnt[2] - m0), 32'd2);
        check_eq("t3_pulses",     32'(pulse_cnt - pc0),   32'd2);
        check_eq("t3_sb_empty",   32'(exp_q.size()),      32'd0);

        // Request on the bit being granted: stays pending, second transfer
        done_delay = 3;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        pc0 = pulse_cnt;
        drive_req(4'b0010);
        wait_pulse("t4_pulse_budget", 10);
        req_i = 4'b0010;
        @(posedge clk);
        #1 req_i = '0;
        @(negedge clk);
        check_eq("t4_pending_kept", 32'(pending_o[1]), 32'd1);
        check_eq("t4_no_merge",     32'(merge_o),      32'd0);
        wait_idle("t4_idle_budget", 100);
        check_eq("t4_pulses",   32'(pulse_cnt - pc0), 32'd2);
        check_eq("t4_sb_empty", 32'(exp_q.size()),    32'd0);

        // Reset in WAIT (grant 2, pending 1010): everything drops, no re-issue
        done_en = 1'b0;
        exp_q.push_back(2'd2);
        drive_req(4'b0100);
        repeat (2) @(negedge clk);
        drive_req(4'b1010);
        @(negedge clk);
        check_eq("t5_pending_pre", 32'(pending_o), 32'hA);
        check_eq("t5_busy_pre",    32'(busy_o),    32'd1);
        check_eq("t5_id_pre",      32'(chan_id),   32'd2);
        #2 reset_l = 1'b0;
        #1;
        check_eq("t5_rst_chan_pulse", 32'(chan_pulse), 32'd0);
        check_eq("t5_rst_chan_id",    32'(chan_id),    32'd0);
        check_eq("t5_rst_pending",    32'(pending_o),  32'd0);
        check_eq("t5_rst_busy",       32'(busy_o),     32'd0);
        check_eq("t5_rst_merge",      32'(merge_o),    32'd0);
        check_eq("t5_rst_timeout",    32'(timeout_o),  32'd0);
        @(posedge clk);
        #1 reset_l = 1'b1;
        pc0 = pulse_cnt;
        repeat (20) @(negedge clk);
        check_eq("t5_no_reissue", 32'(pulse_cnt - pc0), 32'd0);
        check_eq("t5_rr_reset",   32'(dut.rr_q),        32'd0);
        done_en    = 1'b1;
        done_delay = 2;
        exp_q.push_back(2'd3);
        drive_req(4'b1000);
        wait_idle("t5_idle_budget", 50);
        check_eq("t5_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef PULSE_SCHED_TIMEOUT_EN
        // Done withheld: timeout 8 WAIT cycles in, then id 1 goes out
        done_en = 1'b0;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        drive_req(4'b0011);
        wait_pulse("t6_pulse_budget", 10);
        cyc  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            @(negedge clk);
            if (timeout_o) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
        done_en = 1'b1;
        check_eq("t6_timeout_cycle", 32'(cyc),          32'd9);
        check_eq("t6_pending0_clr",  32'(pending_o[0]), 32'd0);
        @(negedge clk);
        check_eq("t6_timeout_width", 32'(timeout_o),  32'd0);
        check_eq("t6_next_issue",    32'(chan_pulse), 32'd1);
        wait_idle("t6_idle_budget", 50);
        check_eq("t6_sb_empty",  32'(exp_q.size()), 32'd0);
        check_eq("t6_tmo_count", 32'(tmo_cnt),      32'd1);
`else
        // Done withheld: no watchdog, transfer stays outstanding
        done_en = 1'b0;
        exp_q.push_back(2'd0);
        drive_req(4'b0001);
        repeat (40) @(negedge clk);
        check_eq("t6_still_busy", 32'(busy_o), 32'd1);
        @(posedge clk);
        #1 chan_done = 1'b1;
        @(posedge clk);
        #1 chan_done = 1'b0;
        done_en = 1'b1;
        wait_idle("t6_idle_budget", 20);
        check_eq("t6_sb_empty",  32'(exp_q.size()), 32'd0);
        check_eq("t6_tmo_count", 32'(tmo_cnt),      32'd0);
`endif

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
